// File: rtl/drv_ad747x.sv
// -----------------------------------------------------------------------------
// drv_ad747x
// Capture-side driver for the AD7476/AD7477/AD7478 serial ADC. A trig starts
// one adcCs/adcSclk frame; the 16 serial bits are shifted in MSB first and
// the conversion result is presented on an Avalon-ST source.
//
// Ports
//   clk, reset    single clock, synchronous active-high reset
//   trig          conversion request (accepted only when idle)
//   busy          high from the cycle after an accepted trig to end of quiet
//   trigMiss      one-cycle pulse (cycle after) for a trig seen while busy
//   asoValid      Avalon-ST valid
//   asoData       sample, straight binary or MSB-inverted (SIGN="SIGNED")
//   asoRdy        Avalon-ST ready
//   overrun       sticky: an unread sample was overwritten
//   clrOvr        clears overrun (a simultaneous set wins)
//   adcCs         ADC chip select, active low
//   adcSclk       ADC serial clock, idles high, registered
//   adcSdata      ADC serial data, changes on falling adcSclk
//   fsm_state     current FSM state (IDLE=0, FRAME=1, QUIET=2)
// -----------------------------------------------------------------------------
module drv_ad747x #(
   parameter string SIGN           = "UNSIGNED",
   parameter int    DATA_WIDTH     = 12,
   parameter int    SCLK_DIVIDER   = 2,
   parameter int    QUIET_DURATION = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  trig,
   output logic                  busy,
   output logic                  trigMiss,
   output logic                  asoValid,
   output logic [DATA_WIDTH-1:0] asoData,
   input  logic                  asoRdy,
   output logic                  overrun,
   input  logic                  clrOvr,
   output logic                  adcCs,
   output logic                  adcSclk,
   input  logic                  adcSdata,
   output logic [1:0]            fsm_state
);

   // Handshake: a sample moves whenever asoValid && asoRdy in the same cycle;
   // asoData is held while asoValid=1 and asoRdy=0; a new sample arriving
   // without a transfer overwrites asoData and sets overrun.

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FRAME = 2'd1;
   localparam logic [1:0] S_QUIET = 2'd2;

   localparam int HC_W = (SCLK_DIVIDER > 1) ? $clog2(SCLK_DIVIDER) : 1;
   localparam logic [HC_W-1:0] HC_LAST = HC_W'(SCLK_DIVIDER - 1);

   localparam int QUIET_CLKS = QUIET_DURATION * 2 * SCLK_DIVIDER;
   localparam int QC_W = $clog2(QUIET_CLKS);
   localparam logic [QC_W-1:0] QC_LAST = QC_W'(QUIET_CLKS - 1);

   localparam bit IS_SIGNED = (SIGN == "SIGNED");
   localparam logic [DATA_WIDTH-1:0] SIGN_MASK =
      IS_SIGNED ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {DATA_WIDTH{1'b0}};

   logic [1:0]            state;
   logic [HC_W-1:0]       hc;
   logic [5:0]            ph;
   logic [QC_W-1:0]       qc;
   logic [15:0]           shreg;
   logic                  phase_end;
   logic [5:0]            ph_next;
   logic [DATA_WIDTH-1:0] sample;
   logic                  unused_bits;

   assign phase_end = (hc == HC_LAST);
   assign ph_next   = ph + 6'd1;

   // shreg[15:12] hold the four leading zeros; the sample starts at b4.
   assign sample      = shreg[11 -: DATA_WIDTH] ^ SIGN_MASK;
   assign unused_bits = ^shreg;

   assign busy      = (state != S_IDLE);
   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         hc       <= '0;
         ph       <= '0;
         qc       <= '0;
         shreg    <= '0;
         adcCs    <= 1'b1;
         adcSclk  <= 1'b1;
         asoValid <= 1'b0;
         asoData  <= '0;
         trigMiss <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         trigMiss <= trig && (state != S_IDLE);

         // Defaults for the output side; a sample load below overrides them.
         if (asoValid && asoRdy) asoValid <= 1'b0;
         if (clrOvr)             overrun  <= 1'b0;

         case (state)
            S_IDLE: begin
               if (trig) begin
                  state <= S_FRAME;
                  adcCs <= 1'b0;
                  hc    <= '0;
                  ph    <= '0;
                  shreg <= '0;
               end
            end

            S_FRAME: begin
               if (phase_end) begin
                  hc <= '0;
                  // Sample at the end of setup and each high phase up to ph=30,
                  // just before the next falling edge moves the data.
                  if (!ph[0] && (ph <= 6'd30))
                     shreg <= {shreg[14:0], adcSdata};
                  if (ph == 6'd32) begin
                     state    <= S_QUIET;
                     qc       <= '0;
                     adcCs    <= 1'b1;
                     adcSclk  <= 1'b1;
                     asoData  <= sample;
                     asoValid <= 1'b1;
                     if (asoValid && !asoRdy) overrun <= 1'b1;
                  end else begin
                     ph      <= ph_next;
                     // Odd phases drive the clock low, even phases high.
                     adcSclk <= ~ph_next[0];
                  end
               end else begin
                  hc <= hc + HC_W'(1);
               end
            end

            S_QUIET: begin
               if (qc == QC_LAST) state <= S_IDLE;
               else               qc    <= qc + QC_W'(1);
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
